// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the register file write port; REGFILE_CLEAR_EN adds post-reset zeroing
module regfile_write_arbiter #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [4:0]       req0_addr,
    input  logic [Width-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [4:0]       req1_addr,
    input  logic [Width-1:0] req1_data,
    output logic             req1_ready,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [Width-1:0] rf_wdata,
    output logic             init_busy
);

`ifdef REGFILE_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_ARB   = 1'b1;

    logic [0:0] state;
    logic [4:0] clr_ptr;
    logic       arb_en;

    assign arb_en    = (state == ST_ARB);
    assign init_busy = (state == ST_CLEAR);
`else
    logic arb_en;

    assign arb_en    = 1'b1;
    assign init_busy = 1'b0;
`endif

    // last_grant names the requester that won most recently; the other wins a tie
    logic last_grant;
    logic accept0;
    logic accept1;

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && arb_en) begin
            if (req0_valid && req1_valid) begin
                req0_ready = last_grant;
                req1_ready = !last_grant;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign accept0 = req0_valid && req0_ready;
    assign accept1 = req1_valid && req1_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_waddr   <= 5'd0;
            rf_wdata   <= '0;
            last_grant <= 1'b1;
`ifdef REGFILE_CLEAR_EN
            state      <= ST_CLEAR;
            clr_ptr    <= 5'd1;
`endif
        end else
`ifdef REGFILE_CLEAR_EN
        if (state == ST_CLEAR) begin
            rf_we    <= 1'b1;
            rf_waddr <= clr_ptr;
            rf_wdata <= '0;
            clr_ptr  <= clr_ptr + 5'd1;
            if (clr_ptr == 5'd31) begin
                state <= ST_ARB;
            end
        end else
`endif
        begin
            rf_we <= 1'b0;
            // x0 writes are consumed but never reach the register file
            if (accept0) begin
                last_grant <= 1'b0;
                if (req0_addr != 5'd0) begin
                    rf_we    <= 1'b1;
                    rf_waddr <= req0_addr;
                    rf_wdata <= req0_data;
                end
            end else if (accept1) begin
                last_grant <= 1'b1;
                if (req1_addr != 5'd0) begin
                    rf_we    <= 1'b1;
                    rf_waddr <= req1_addr;
                    rf_wdata <= req1_data;
                end
            end
        end
    end

endmodule
